// File: rtl/sram1rw_req_ctrl.sv
// sram1rw_req_ctrl: request/response front end for a 1RW SRAM macro.
// Optional write acks via macro SRAM_CTRL_WRITE_ACK_EN.
//
// Ports:
//   clock, reset_n            clock (also macro CE), async active-low reset
//   req_valid/req_ready       request handshake
//   req_write/req_addr/req_wdata  request payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_write       response payload (head of response FIFO)
//   sram_A/I/CSB/WEB/OEB/O    macro pins
//   busy                      a read is in flight or buffered
module sram1rw_req_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_I,
  output logic              sram_CSB,
  output logic              sram_WEB,
  output logic              sram_OEB,
  input  logic [DATA_W-1:0] sram_O,
  output logic              busy
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic              pending;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic [OW-1:0]     occ;
  logic [OW-1:0]     occ_left;
  logic              pop;
  logic              push;
  logic              accept;
  logic              take;
  logic [DATA_W-1:0] push_data;

  assign rsp_valid = count != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign occ       = {1'b0, count} + OW'(pending);
  // a pop this cycle frees its slot in time for a new accept
  assign occ_left  = occ - OW'(pop);
  assign req_ready = reset_n & (occ_left < OW'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign busy      = occ != '0;
  assign push      = pending;

  assign sram_A = req_addr;
  assign sram_I = req_wdata;

  always_comb begin
    sram_CSB = 1'b1;
    sram_WEB = 1'b1;
    sram_OEB = 1'b1;
    if (accept) begin
      sram_CSB = 1'b0;
      if (req_write) sram_WEB = 1'b0;
      else           sram_OEB = 1'b0;
    end
  end

`ifdef SRAM_CTRL_WRITE_ACK_EN
  logic                pend_wr;
  logic [RSP_DEPTH-1:0] wflag;

  assign take      = accept;
  assign push_data = pend_wr ? '0 : sram_O;
  assign rsp_write = wflag[rptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_wr <= 1'b0;
      wflag   <= '0;
    end else begin
      pend_wr <= req_write;
      if (push) wflag[wptr] <= pend_wr;
    end
  end
`else
  assign take      = accept & ~req_write;
  assign push_data = sram_O;
  assign rsp_write = 1'b0;
`endif

  // pending marks the cycle in which macro O carries the
  // data of the op accepted in the previous cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending <= 1'b0;
    else          pending <= take;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign rsp_rdata = mem[rptr];

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// tb_sram1rw_req_ctrl: directed bench for sram1rw_req_ctrl
// with a behavioural 1RW macro model.
module tb_sram1rw_req_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic [9:0]  sram_A;
  logic [31:0] sram_I;
  logic        sram_CSB;
  logic        sram_WEB;
  logic        sram_OEB;
  logic [31:0] sram_O = '0;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ram [1024];

  sram1rw_req_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_write (rsp_write),
    .sram_A    (sram_A),
    .sram_I    (sram_I),
    .sram_CSB  (sram_CSB),
    .sram_WEB  (sram_WEB),
    .sram_OEB  (sram_OEB),
    .sram_O    (sram_O),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // macro: registered read, O held until the next read
  always @(posedge clock) begin
    if (!sram_CSB) begin
      if (!sram_WEB)      ram[sram_A] <= sram_I;
      else if (!sram_OEB) sram_O <= ram[sram_A];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic rd(input logic [9:0] a);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 8; i++)
      ram[i] = 32'(i) * 32'h11111111;

    // reset state
    neg();
    chk("rst_csb", sram_CSB, 1);
    chk("rst_web", sram_WEB, 1);
    chk("rst_oeb", sram_OEB, 1);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rd", rsp_rdata, 0);
    chk("rst_rw", rsp_write, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    step();

    // async reset mid-cycle kills the accept at once
    rd(10'd0);
    #1;
    chk("pre_csb", sram_CSB, 0);
    reset_n = 1'b0;
    #1;
    chk("ar_csb", sram_CSB, 1);
    chk("ar_oeb", sram_OEB, 1);
    chk("ar_web", sram_WEB, 1);
    chk("ar_rdy", req_ready, 0);
    chk("ar_rv", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    idle();
    reset_n = 1'b1;
    step();

    // write then read 0x3FF
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h3FF;
    req_wdata = 32'hDEADBEEF;
    neg();
    chk("w_rdy", req_ready, 1);
    chk("w_csb", sram_CSB, 0);
    chk("w_web", sram_WEB, 0);
    chk("w_oeb", sram_OEB, 1);
    chk("w_a", sram_A, 10'h3FF);
    chk("w_i", sram_I, 32'hDEADBEEF);
    step();
    rd(10'h3FF);
    neg();
    chk("r_csb", sram_CSB, 0);
    chk("r_oeb", sram_OEB, 0);
    chk("r_web", sram_WEB, 1);
    chk("r_busy0", busy, 0);
    step();
    idle();
    neg();
    chk("r_t1_rv", rsp_valid, 0);
    chk("r_t1_csb", sram_CSB, 1);
    chk("r_t1_busy", busy, 1);
    step();
    neg();
    chk("r_t2_rv", rsp_valid, 1);
    chk("r_t2_d", rsp_rdata, 32'hDEADBEEF);
    chk("r_t2_w", rsp_write, 0);
    step();
    neg();
    chk("r_t3_rv", rsp_valid, 0);
    chk("r_t3_busy", busy, 0);
    step();

    // streaming 8 reads
    for (int c = 0; c < 10; c++) begin
      if (c < 8) rd(10'(c));
      else idle();
      neg();
      if (c < 8) chk("s_rdy", req_ready, 1);
      if (c >= 2) begin
        chk("s_rv", rsp_valid, 1);
        chk("s_d", rsp_rdata, 32'(c - 2) * 32'h11111111);
      end
      step();
    end
    neg();
    chk("s_end_rv", rsp_valid, 0);
    step();

    // backpressure
    rsp_ready = 1'b0;
    rd(10'd1);
    neg();
    chk("bp_rdy0", req_ready, 1);
    step();
    rd(10'd2);
    neg();
    chk("bp_rdy1", req_ready, 1);
    step();
    rd(10'd3);
    neg();
    chk("bp_rdy2", req_ready, 0);
    chk("bp_oeb2", sram_OEB, 1);
    step();
    neg();
    chk("bp_rdy3", req_ready, 0);
    chk("bp_cnt", dut.count <= 2, 1);
    chk("bp_rv3", rsp_valid, 1);
    step();
    rsp_ready = 1'b1;
    #1;
    chk("bp_rdy4", req_ready, 1);
    neg();
    chk("bp_d4", rsp_rdata, 32'h11111111);
    step();
    idle();
    neg();
    chk("bp_rv5", rsp_valid, 1);
    chk("bp_d5", rsp_rdata, 32'h22222222);
    step();
    neg();
    chk("bp_rv6", rsp_valid, 1);
    chk("bp_d6", rsp_rdata, 32'h33333333);
    step();
    neg();
    chk("bp_rv7", rsp_valid, 0);
    chk("bp_busy7", busy, 0);
    step();

    // read / write / read hazard at address 5
    ram[5] = 32'h1;
    rd(10'd5);
    step();
    req_write = 1'b1;
    req_wdata = 32'h2;
    step();
    rd(10'd5);
    neg();
    chk("hz_rv2", rsp_valid, 1);
    chk("hz_d2", rsp_rdata, 32'h1);
    step();
    idle();
    neg();
    chk("hz_rv3", rsp_valid, 0);
    step();
    neg();
    chk("hz_rv4", rsp_valid, 1);
    chk("hz_d4", rsp_rdata, 32'h2);
    step();

    // reset while a read is in flight
    rd(10'd3);
    step();
    idle();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    neg();
    chk("rr_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      neg();
      chk("rr_rv", rsp_valid, 0);
    end
    step();
    rd(10'd7);
    step();
    idle();
    neg();
    chk("rr_rv1", rsp_valid, 0);
    step();
    neg();
    chk("rr_rv2", rsp_valid, 1);
    chk("rr_d2", rsp_rdata, 32'h77777777);
    step();
    neg();
    chk("rr_rv3", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram1rw_req_ctrl.md
Name: sram1rw_req_ctrl

Overview:
- Initiator-side controller for a single-port 1RW SRAM macro: 10-bit address, 32-bit data, active-low CSB/WEB/OEB, registered read data.
- The macro samples on its CE rising edge; CE is tied to this block's clock.
- Converts a valid/ready request channel from core logic into macro pin activity.
- Returns read data on a valid/ready response channel through a credit-checked response FIFO, so backpressure never loses macro output.

Parameters:
- ADDR_W, 10, address width; drives macro A.
- DATA_W, 32, data width; drives macro I and receives macro O.
- RSP_DEPTH, 2, response FIFO entries; power of 2, at least 2.

Ports:
- clock  in  1  block clock; also the macro CE.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DATA_W  read data.
- rsp_write  out  1  response tag; always 0 unless the optional feature is compiled in.
- sram_A  out  ADDR_W  macro address; passes req_addr through.
- sram_I  out  DATA_W  macro write data; passes req_wdata through.
- sram_CSB  out  1  macro chip select, active low.
- sram_WEB  out  1  macro write enable, active low.
- sram_OEB  out  1  macro read enable, active low.
- sram_O  in  DATA_W  macro read data.
- busy  out  1  high when any read is in flight or buffered.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Flush the FIFO; clear pointers, count and pending.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_write=0, busy=0, req_ready=0.
  - Macro pins: sram_CSB=1, sram_WEB=1, sram_OEB=1.
- Reset mid-operation: an in-flight read is dropped; its macro output is never pushed.
- Request accept: accept = req_valid & req_ready. Macro pins are combinational from the accepted request, so the macro samples at the same edge:
  - Read: CSB=0, OEB=0, WEB=1.
  - Write: CSB=0, WEB=0, OEB=1.
  - No accept: CSB=WEB=OEB=1.
  - A and I pass through unconditionally.
- Credit rule:
  - occ = fifo_count + pending.
  - pop = rsp_valid & rsp_ready.
  - req_ready = reset_n & ((occ - pop) < RSP_DEPTH).
  - Writes use the same rule; req_ready never depends on req_write.
  - The combinational path rsp_ready -> req_ready is intended.
- pending register:
  - Set at the edge that accepts a read.
  - Cleared at the next edge, unless a back-to-back read re-sets it.
- Push: at the edge ending any cycle where pending=1, push sram_O. The macro holds O from its read edge until its next read edge, so this capture is exact.
- Read latency: accept in cycle t; rsp_valid no earlier than cycle t+2. Throughput is one read per cycle while rsp_ready=1.
- Response output: rsp_valid = fifo_count != 0. rsp_rdata/rsp_write come from the head entry (registered storage).
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping modulo RSP_DEPTH.
- Full/empty:
  - Overflow is impossible by construction.
  - Pop on empty is ignored.
  - Bench asserts count <= RSP_DEPTH.
- Writes produce no response and do not touch the FIFO.
- Read then write to the same address on consecutive cycles: the response returns the old data.
- busy = occ != 0.

Optional Feature:
- SRAM_CTRL_WRITE_ACK_EN defined:
  - Every accepted write also occupies a credit.
  - It pushes an entry with rsp_write=1 and rsp_rdata=0, with the same latency as a read, giving in-order ack for writes.
- Undefined:
  - Writes consume no credit and rsp_write is tied to 0.

Test Plan:
- Reset: pulse reset_n low asynchronously mid-cycle -> immediately CSB=WEB=OEB=1, rsp_valid=0, req_ready=0, busy=0.
- Write/read: write 0xDEADBEEF @0x3FF, then read 0x3FF with rsp_ready=1 -> CSB/WEB low during the write only; OEB low during the read only; rsp_valid 2 cycles after read accept with rsp_rdata=0xDEADBEEF.
- Streaming: 8 back-to-back reads @0..7 (preloaded with addr*0x11111111), rsp_ready=1 -> req_ready stays 1; 8 responses in order on consecutive cycles.
- Backpressure: rsp_ready=0 with reads streamed -> req_ready drops after RSP_DEPTH accepts. Raise rsp_ready -> same-cycle req_ready=1; no data lost or duplicated.
- Hazard: read @5 (value 0x1), write 0x2 @5 the next cycle, read @5 again -> responses 0x1 then 0x2.
- Reset during an in-flight read (cycle t+1) -> no response after reset release; the next read returns correct data.
